// File: rtl/frame_receiver_if.sv
// rtl/frame_receiver_if.sv - payload byte stream from frame_receiver toward the UART TX FIFO
`timescale 1ns/1ps
interface frame_receiver_if;
  logic [7:0] pyld_data;
  logic       pyld_data_valid;
  logic       pyld_data_ready;

  modport master (output pyld_data, output pyld_data_valid, input pyld_data_ready);
  modport slave  (input pyld_data, input pyld_data_valid, output pyld_data_ready);
endinterface

// File: rtl/frame_receiver.sv
// rtl/frame_receiver.sv - OTN line receiver: UART 8N1 deserializer, frame hunt, CRC-8 check, ARQ ACK, payload drain
`timescale 1ns/1ps
module frame_receiver #(
  parameter int         PYLD_BYTES = 16,
  parameter logic [7:0] FAS0       = 8'hF6,
  parameter logic [7:0] FAS1       = 8'h28,
  parameter int         ACK_CYCLES = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sclk_en_16_x_baud,
  input  logic             i_otn_rx_data,
  input  logic             i_arq_en,
  output logic             o_otn_tx_ack,
  frame_receiver_if.master m_pyld,
  output logic [7:0]       o_crc_val,
  output logic             o_crc_err,
  output logic             o_frame_err
);
  localparam int IW = (PYLD_BYTES > 1) ? $clog2(PYLD_BYTES) : 1;
  localparam int AW = $clog2(ACK_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(PYLD_BYTES - 1);
  localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_CYCLES);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_t;
  typedef enum logic [2:0] {F_HUNT0, F_HUNT1, F_PYLD, F_CRCB, F_DRAIN} frame_t;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  // Reset asserts asynchronously but releases on a clock edge
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [1:0] r_rx_sync;
  logic       w_rx;
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_rx_sync <= 2'b11;
    else          r_rx_sync <= {r_rx_sync[0], i_otn_rx_data};
  end
  assign w_rx = r_rx_sync[1];

  uart_t      r_ust, w_ust_nxt;
  logic [3:0] r_tick, w_tick_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_byte_valid, w_byte_valid_nxt;
  logic       r_stop_err, w_stop_err_nxt;

  always_comb begin
    w_ust_nxt        = r_ust;
    w_tick_nxt       = r_tick;
    w_bit_nxt        = r_bit;
    w_shift_nxt      = r_shift;
    w_byte_valid_nxt = 1'b0;
    w_stop_err_nxt   = 1'b0;
    if (i_sclk_en_16_x_baud) begin
      w_tick_nxt = r_tick + 4'd1;
      case (r_ust)
        U_IDLE: begin
          w_tick_nxt = 4'd0;
          if (!w_rx) w_ust_nxt = U_START;
        end
        U_START: if (r_tick == 4'd7) begin
          w_tick_nxt = 4'd0;
          w_bit_nxt  = 3'd0;
          w_ust_nxt  = w_rx ? U_IDLE : U_DATA;
        end
        U_DATA: if (r_tick == 4'd15) begin
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_ust_nxt = U_STOP;
        end
        U_STOP: if (r_tick == 4'd15) begin
          w_byte_valid_nxt = w_rx;
          w_stop_err_nxt   = !w_rx;
          w_ust_nxt        = U_IDLE;
        end
        default: w_ust_nxt = U_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ust        <= U_IDLE;
      r_tick       <= 4'd0;
      r_bit        <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_ust        <= w_ust_nxt;
      r_tick       <= w_tick_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_stop_err   <= w_stop_err_nxt;
    end
  end

  frame_t        r_fst, w_fst_nxt;
  logic [IW-1:0] r_wr_idx, r_rd_idx, w_rd_nxt;
  logic [7:0]    r_crc, w_crc_upd, r_crc_val, r_data;
  logic [7:0]    r_buf [PYLD_BYTES];
  logic [AW-1:0] r_ack_cnt;
  logic          r_valid, r_crc_err, r_frame_err, w_xfer;
  logic          w_buf_we, w_pyld_enter, w_crc_bad, w_frame_bad, w_ack_start, w_drain_enter;

  assign w_xfer    = r_valid && m_pyld.pyld_data_ready;
  assign w_rd_nxt  = r_rd_idx + 1'b1;
  assign w_crc_upd = crc8_step(r_crc, r_shift);

  always_comb begin
    w_fst_nxt     = r_fst;
    w_buf_we      = 1'b0;
    w_pyld_enter  = 1'b0;
    w_crc_bad     = 1'b0;
    w_frame_bad   = 1'b0;
    w_ack_start   = 1'b0;
    w_drain_enter = 1'b0;
    case (r_fst)
      F_HUNT0: if (r_byte_valid && r_shift == FAS0) w_fst_nxt = F_HUNT1;
      F_HUNT1: begin
        if (r_stop_err) begin
          w_frame_bad = 1'b1;
          w_fst_nxt   = F_HUNT0;
        end else if (r_byte_valid) begin
          if (r_shift == FAS1) begin
            w_fst_nxt    = F_PYLD;
            w_pyld_enter = 1'b1;
          end else if (r_shift != FAS0) begin
            w_fst_nxt = F_HUNT0;
          end
        end
      end
      F_PYLD: begin
        if (r_stop_err) begin
          w_frame_bad = 1'b1;
          w_fst_nxt   = F_HUNT0;
        end else if (r_byte_valid) begin
          w_buf_we = 1'b1;
          if (r_wr_idx == LAST_IDX) w_fst_nxt = F_CRCB;
        end
      end
      F_CRCB: begin
        if (r_stop_err) begin
          w_frame_bad = 1'b1;
          w_fst_nxt   = F_HUNT0;
        end else if (r_byte_valid) begin
          if (r_shift == r_crc) begin
            w_fst_nxt     = F_DRAIN;
            w_drain_enter = 1'b1;
            w_ack_start   = i_arq_en;
          end else begin
            // Without ARQ the sender cannot retransmit, so the payload is delivered anyway
            w_crc_bad     = 1'b1;
            w_fst_nxt     = i_arq_en ? F_HUNT0 : F_DRAIN;
            w_drain_enter = !i_arq_en;
          end
        end
      end
      F_DRAIN: if (w_xfer && r_rd_idx == LAST_IDX) w_fst_nxt = F_HUNT0;
      default: w_fst_nxt = F_HUNT0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_buf_we) r_buf[r_wr_idx] <= r_shift;
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fst       <= F_HUNT0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_crc       <= 8'd0;
      r_crc_val   <= 8'd0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_ack_cnt   <= '0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_fst       <= w_fst_nxt;
      r_crc_err   <= w_crc_bad;
      r_frame_err <= w_frame_bad;
      if (w_pyld_enter) begin
        r_crc    <= 8'd0;
        r_wr_idx <= '0;
      end else if (w_buf_we) begin
        r_crc    <= w_crc_upd;
        r_wr_idx <= r_wr_idx + 1'b1;
      end
      if (r_fst == F_CRCB && r_byte_valid) r_crc_val <= r_crc;
      if (w_ack_start)            r_ack_cnt <= ACK_LOAD;
      else if (r_ack_cnt != '0)   r_ack_cnt <= r_ack_cnt - 1'b1;
      if (w_drain_enter) begin
        r_rd_idx <= '0;
        r_valid  <= 1'b0;
      end else if (r_fst == F_DRAIN) begin
        if (!r_valid) begin
          r_valid <= 1'b1;
          r_data  <= r_buf[r_rd_idx];
        end else if (m_pyld.pyld_data_ready) begin
          if (r_rd_idx == LAST_IDX) begin
            r_valid <= 1'b0;
          end else begin
            r_rd_idx <= w_rd_nxt;
            r_data   <= r_buf[w_rd_nxt];
          end
        end
      end
    end
  end

  assign o_otn_tx_ack           = (r_ack_cnt != '0);
  assign m_pyld.pyld_data       = r_data;
  assign m_pyld.pyld_data_valid = r_valid;
  assign o_crc_val              = r_crc_val;
  assign o_crc_err              = r_crc_err;
  assign o_frame_err            = r_frame_err;
endmodule

// File: doc/frame_receiver.md
Name: frame_receiver

Overview:
- Far-end counterpart of the sender's transmit/ARQ path.
- Receives the serial OTN line (UART 8N1 bytes, 16x oversampled), hunts for frame alignment, buffers one payload and checks its CRC-8.
- Acknowledges good frames on the ACK line when ARQ is enabled.
- Delivers verified payload bytes on a valid/ready stream toward the UART TX FIFO.

Parameters:
- PYLD_BYTES, 16: payload bytes per frame (2..64).
- FAS0, 8'hF6: first frame-alignment byte.
- FAS1, 8'h28: second frame-alignment byte.
- ACK_CYCLES, 64: i_clk cycles o_otn_tx_ack is held high per good frame (>=1).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sclk_en_16_x_baud  in  1  one-cycle strobe at 16x baud.
- i_otn_rx_data  in  1  serial line; idle high.
- i_arq_en  in  1  ARQ enable switch.
- o_otn_tx_ack  out  1  ACK line back to sender.
- o_pyld_data  out  8  payload byte.
- o_pyld_data_valid  out  1  payload byte valid.
- i_pyld_data_ready  in  1  downstream ready.
- o_crc_val  out  8  CRC computed over the last complete frame.
- o_crc_err  out  1  one-cycle pulse on CRC mismatch.
- o_frame_err  out  1  one-cycle pulse on a UART stop-bit error inside a frame.

Behaviour:
- Reset (async assert, sync deassert internally):
  - All outputs are 0.
  - FSM is in HUNT0, payload buffer is empty, and the synchronizer flops are set to 1.
- Line input path:
  - 2-flop synchronizer on i_otn_rx_data.
  - All UART timing advances only on cycles with i_sclk_en_16_x_baud = 1.
- UART byte receiver:
  - IDLE: synchronized line = 0 on a strobe -> START.
  - START: after 8 strobes, resample. 0 -> DATA; 1 -> IDLE (glitch, no byte).
  - DATA: sample every 16 strobes, 8 bits, LSB first.
  - STOP: sample after 16 strobes. 1 -> one-cycle byte_valid with the byte. 0 -> byte discarded and stop_err pulsed.
  - Return to IDLE in either case.
- Frame FSM, advances only on byte_valid or stop_err:
  - HUNT0: byte == FAS0 -> HUNT1.
  - HUNT1: byte == FAS1 -> PYLD. byte == FAS0 -> stay in HUNT1. Otherwise -> HUNT0.
  - PYLD: write byte into buffer[idx] and update CRC. idx == PYLD_BYTES-1 -> CRCB.
  - CRCB: latch the computed CRC into o_crc_val.
    - Received byte == computed CRC -> DRAIN, and start the ACK timer if i_arq_en = 1.
    - Mismatch, i_arq_en = 1 -> pulse o_crc_err, discard the buffer, go to HUNT0.
    - Mismatch, i_arq_en = 0 -> pulse o_crc_err, still go to DRAIN (no retransmission is possible).
  - DRAIN: present buffer bytes in order. After the byte at index PYLD_BYTES-1 is accepted -> HUNT0. Bytes received while in DRAIN are dropped.
  - stop_err in HUNT1, PYLD or CRCB -> pulse o_frame_err, go to HUNT0, discard the buffer. stop_err in HUNT0 or DRAIN is ignored.
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - Covers payload bytes only. Accumulator is cleared on entry to PYLD.
- Output handshake (AXI-stream rules):
  - o_pyld_data is registered from the buffer.
  - Valid is asserted the cycle after entering DRAIN.
  - Data and valid are held stable until valid & ready.
  - Back-to-back transfers are allowed: one byte per cycle while ready = 1.
  - Latency from the CRC byte's stop-bit sample to first valid is 2 cycles.
- ACK:
  - o_otn_tx_ack goes high the cycle after a CRC match when i_arq_en = 1.
  - It stays high exactly ACK_CYCLES cycles, independent of DRAIN progress.
  - A new good frame while the ACK is still high restarts the count.
  - With i_arq_en = 0, o_otn_tx_ack stays 0.
- i_arq_en is sampled at the CRCB decision only.
- Reset asserted mid-frame or mid-drain aborts immediately: valid drops and the ACK drops.

Test Plan (bench: PYLD_BYTES=4, ACK_CYCLES=64, strobe every 4 cycles):
- Frame F6 28 00 00 00 01 07, arq=1 -> o_crc_val=0x07, ACK high exactly 64 cycles, stream 00 00 00 01 then valid=0, no error pulses.
- Same frame with CRC byte 06, arq=1 -> o_crc_err pulses once, o_crc_val=0x07, ACK stays 0, no payload output, next good frame is accepted.
- CRC byte 06, arq=0 -> o_crc_err pulses, ACK stays 0, stream 00 00 00 01 still delivered.
- Prefix junk 11 F6 F6 28, then good all-zero payload with CRC 00 -> lock achieved, ACK pulses, 4 zero bytes delivered.
- Good frame with i_pyld_data_ready toggling 1/0 each cycle -> no byte lost or duplicated, data stable while valid & !ready.
- Stop bit forced 0 on the 2nd payload byte -> o_frame_err pulses, FSM back to HUNT0, no ACK; reset asserted mid-DRAIN -> all outputs 0 asynchronously.
